// File: rtl/mu_sweep_gen.sv
// Logistic-map mu generator: preset lookup or linear sweep.
// Emits a prescaled calc_en strobe and first-iteration flag per point.
module mu_sweep_gen #(
   parameter int MU_W    = 18,
   parameter int DIV_W   = 16,
   parameter int DWELL_W = 12,
   parameter int CNT_W   = 10
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               start,
   input  logic               stop,
   input  logic               mode,
   input  logic [3:0]         preset_sel,
   input  logic [MU_W-1:0]    mu_start,
   input  logic [MU_W-1:0]    mu_step,
   input  logic [CNT_W-1:0]   num_steps,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [DIV_W-1:0]   div,
   output logic [MU_W-1:0]    mu,
   output logic               calc_en,
   output logic               first_iter,
   output logic [CNT_W-1:0]   step_idx,
   output logic               busy,
   output logic               done
);

   typedef enum logic {IDLE, RUN} state_t;

   // 18-bit reference codes, left-aligned into MU_W bits
   function automatic logic [MU_W-1:0] preset_mu(input logic [3:0] sel);
      logic [17:0]     code;
      logic [MU_W-1:0] r;
      case (sel)
         4'd0:    code = 18'h0CCCC;
         4'd1:    code = 18'h13333;
         4'd2:    code = 18'h31999;
         4'd3:    code = 18'h37333;
         4'd4:    code = 18'h38CCD;
         4'd5:    code = 18'h390A4;
         4'd6:    code = 18'h390E5;
         4'd7:    code = 18'h39127;
         4'd8:    code = 18'h391EC;
         4'd9:    code = 18'h3947B;
         4'd10:   code = 18'h3FFFF;
         default: code = 18'h00000;
      endcase
      r = '0;
      for (int i = 0; i < MU_W; i++) begin
         if (i < 18) r[MU_W-1-i] = code[17-i];
      end
      return r;
   endfunction

   state_t             state_q, state_d;
   logic [MU_W-1:0]    mu_q, mu_d;
   logic               calc_en_q, calc_en_d;
   logic               first_q, first_d;
   logic [CNT_W-1:0]   step_idx_q, step_idx_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [DIV_W-1:0]   pre_q, pre_d;
   logic [DWELL_W-1:0] dwc_q, dwc_d;
   logic [MU_W-1:0]    step_q, step_d;
   logic [CNT_W-1:0]   lst_q, lst_d;
   logic [DWELL_W-1:0] dwl_q, dwl_d;
   logic [DIV_W-1:0]   div_q, div_d;

   logic [DIV_W-1:0]   pre_nxt;
   logic [MU_W:0]      sum;
   logic [MU_W-1:0]    mu_sat;
   logic               last_pulse;
   logic               last_point;

   // Saturating mu increment and end-of-point / end-of-run detection
   always_comb begin
      sum        = {1'b0, mu_q} + {1'b0, step_q};
      mu_sat     = sum[MU_W] ? '1 : sum[MU_W-1:0];
      pre_nxt    = (pre_q == div_q) ? '0 : pre_q + 1'b1;
      last_pulse = calc_en_q && (dwc_q == dwl_q);
      last_point = (step_idx_q == lst_q);
   end

   // Next-state logic: run control, prescaler, dwell and point sequencing
   always_comb begin
      state_d    = state_q;
      mu_d       = mu_q;
      calc_en_d  = 1'b0;
      first_d    = 1'b0;
      step_idx_d = step_idx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      pre_d      = pre_q;
      dwc_d      = dwc_q;
      step_d     = step_q;
      lst_d      = lst_q;
      dwl_d      = dwl_q;
      div_d      = div_q;
      case (state_q)
         IDLE: begin
            if (start && !stop) begin
               state_d    = RUN;
               busy_d     = 1'b1;
               mu_d       = mode ? mu_start : preset_mu(preset_sel);
               step_idx_d = '0;
               pre_d      = '0;
               dwc_d      = '0;
               step_d     = mu_step;
               div_d      = div;
               dwl_d      = (dwell == '0) ? '0 : dwell - 1'b1;
               lst_d      = (mode && num_steps != '0) ?
                            num_steps - 1'b1 : '0;
               calc_en_d  = (div == '0);
               first_d    = (div == '0);
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else if (last_pulse && last_point) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pre_d   = '0;
               dwc_d   = '0;
            end else begin
               pre_d = pre_nxt;
               if (last_pulse) begin
                  mu_d       = mu_sat;
                  step_idx_d = step_idx_q + 1'b1;
                  dwc_d      = '0;
               end else if (calc_en_q) begin
                  dwc_d = dwc_q + 1'b1;
               end
               calc_en_d = (pre_nxt == div_q);
               first_d   = calc_en_d && (dwc_d == '0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         mu_q       <= '0;
         calc_en_q  <= 1'b0;
         first_q    <= 1'b0;
         step_idx_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pre_q      <= '0;
         dwc_q      <= '0;
         step_q     <= '0;
         lst_q      <= '0;
         dwl_q      <= '0;
         div_q      <= '0;
      end else begin
         state_q    <= state_d;
         mu_q       <= mu_d;
         calc_en_q  <= calc_en_d;
         first_q    <= first_d;
         step_idx_q <= step_idx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pre_q      <= pre_d;
         dwc_q      <= dwc_d;
         step_q     <= step_d;
         lst_q      <= lst_d;
         dwl_q      <= dwl_d;
         div_q      <= div_d;
      end
   end

   assign mu         = mu_q;
   assign calc_en    = calc_en_q;
   assign first_iter = first_q;
   assign step_idx   = step_idx_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: doc/mu_sweep_gen.md
Name: mu_sweep_gen

Overview:
Parametrised generator for the logistic-map parameter mu and its iteration strobe. It replaces fixed-table mu selection plus a gated divided clock.
- Two modes: preset table lookup (one point) or linear sweep (start/step/count), for bifurcation plots.
- Emits a single-cycle calc_en strobe from a programmable prescaler on the main clock. No derived clocks.
- Holds each mu for a programmable number of iterations and flags the first iteration of each point so the map core can reseed x.

Parameters:
MU_W, 18, mu width, unsigned fixed point Q2.(MU_W-2)
DIV_W, 16, prescaler reload width
DWELL_W, 12, iterations-per-point counter width
CNT_W, 10, sweep point counter width

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
start  in  1  begin run; sampled only in IDLE
stop  in  1  synchronous abort; return to IDLE without done
mode  in  1  0 = preset, 1 = linear sweep
preset_sel  in  4  preset table index
mu_start  in  MU_W  first mu (linear)
mu_step  in  MU_W  increment per point (linear)
num_steps  in  CNT_W  points in sweep (linear)
dwell  in  DWELL_W  calc_en pulses per point
div  in  DIV_W  calc_en period minus 1, in CLK cycles
mu  out  MU_W  current mu, registered
calc_en  out  1  one-cycle iteration strobe
first_iter  out  1  coincident with first calc_en of each point
step_idx  out  CNT_W  index of current point
busy  out  1  run in progress
done  out  1  one-cycle pulse at normal completion

Behaviour:
- Reset (RST low, async): mu=0, calc_en=0, first_iter=0, step_idx=0, busy=0, done=0, FSM=IDLE, prescaler and dwell counters cleared. Reset mid-run discards the run. After release the block stays IDLE until start.
- FSM states: IDLE, RUN.
- IDLE to RUN on start=1. On that edge:
  - latch mode, mu_step, num_steps, dwell, div; config inputs are don't-care afterwards;
  - load mu = mu_start (linear) or PRESET[preset_sel];
  - set step_idx=0, busy=1, prescaler=0, dwell count=0.
- Preset table, 18-bit codes (0.8, 1.2, 3.1, 3.45, 3.55, and the onset-of-chaos region):
  - index 0..4: 0x0CCCC, 0x13333, 0x31999, 0x37333, 0x38CCD;
  - index 5..10: 0x390A4, 0x390E5, 0x39127, 0x391EC, 0x3947B, 0x3FFFF;
  - index 11..15: 0;
  - MU_W>18: codes padded with zero LSBs. MU_W<18: LSBs truncated.
- Prescaler in RUN:
  - counts 0..div; calc_en=1 for one cycle when count==div, and the count wraps to 0;
  - the first calc_en is in cycle div+1 after the start edge, then every div+1 cycles;
  - div=0 gives calc_en continuously high.
- first_iter=1 only with the first calc_en of each point.
- Dwell: dwell=0 is treated as 1. After the dwell-th calc_en of a point (the last pulse), on the edge ending that cycle:
  - if more points remain: mu <= sat(mu + mu_step), step_idx++, dwell count=0; the prescaler keeps running;
  - otherwise: go to IDLE, busy=0, done=1 for exactly one cycle; mu and step_idx hold.
  - A consumer sampling mu with calc_en always sees the point's own mu.
- Point count: linear mode runs max(num_steps,1) points. Preset mode runs one point; num_steps and mu_step are ignored.
- Arithmetic: the MU_W-bit unsigned add saturates to all-ones on carry-out. The sweep continues at saturation.
- start while busy: ignored.
- stop in RUN: on that edge go to IDLE, busy=0, calc_en=0, no done; mu and step_idx hold.
- stop has priority over a coincident final pulse: no done.
- stop in IDLE: no effect. start and stop together in IDLE: stay IDLE.
- Outputs are all registered. There is no combinational path from inputs to outputs.

Test Plan:
- Preset: mode=0, preset_sel=4, dwell=3, div=1, start -> mu=0x38CCD from the cycle after start; calc_en high in cycles 2, 4, 6 after start; first_iter only on the first; done pulses once in the cycle after the 3rd calc_en; busy falls in that same cycle. Repeat with preset_sel=12 -> mu=0.
- Linear: mu_start=0x30000, mu_step=0x01000, num_steps=4, dwell=2, div=0 -> 8 contiguous calc_en; mu 0x30000, 0x31000, 0x32000, 0x33000 for two pulses each; step_idx 0..3; 4 first_iter pulses; one done.
- Saturation: mu_start=0x3F000, mu_step=0x00800, num_steps=4, dwell=1 -> mu sequence 0x3F000, 0x3F800, 0x3FFFF, 0x3FFFF.
- Control: start pulsed while busy -> no effect on mu or step_idx. stop during point 2 of a 4-point sweep -> busy=0 next cycle, no done, mu held. stop coincident with the final calc_en -> no done.
- Reset: drive RST low asynchronously mid-RUN, between clock edges -> all outputs 0 immediately. After release, no calc_en until a new start.
- Zero config: dwell=0, num_steps=0, div=0 in linear mode -> exactly one calc_en with first_iter=1, then done on the next cycle.
